sigmoid_seg_sel: RTL and testbench



---
 rtl/sigmoid_pkg.sv | 39 +++
 rtl/sigmoid_seg_sel_if.sv | 32 +++
 rtl/sigmoid_coef_tbl.sv | 78 +++++++
 rtl/sigmoid_seg_sel.sv | 121 ++++++++++++
 tb/tb_sigmoid_seg_sel.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_pkg
// Shared constants and types for the piecewise-linear sigmoid front end.
//   BITS/FRAC   : Q8.8 sample and coefficient format
//   NSEG        : number of unit-wide linear segments on the positive axis
//   DEF_GRAD/OFF: power-on coefficient table
//   SAT_OFFSET  : offset used once |x| leaves the segmented range (1.0)
//   fold_abs()  : |x| with the most negative code clamped to 0x7FFF
// -----------------------------------------------------------------------------
package sigmoid_pkg;

  localparam int BITS = 16;
  localparam int FRAC = 8;
  localparam int NSEG = 6;

  typedef logic [BITS-1:0]      word_t;
  typedef logic [BITS-FRAC-1:0] seg_t;

  localparam word_t SAT_OFFSET = 16'h0100;

  localparam word_t DEF_GRAD [NSEG] = '{16'h003B, 16'h0026, 16'h0012,
                                        16'h0008, 16'h0003, 16'h0001};
  localparam word_t DEF_OFF  [NSEG] = '{16'h0080, 16'h0090, 16'h00BD,
                                        16'h00DD, 16'h00F0, 16'h00F9};

  // Two's-complement magnitude; 0x8000 has no positive twin so it clamps.
  function automatic word_t fold_abs(input word_t x);
    word_t r;
    if (x == 16'h8000) begin
      r = 16'h7FFF;
    end else if (x[BITS-1]) begin
      r = (~x) + 16'h0001;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/sigmoid_seg_sel_if.sv
// -----------------------------------------------------------------------------
// sigmoid_seg_sel_if
// Input (valid/ready + sample) and output (valid/ready + segment data) bus of
// sigmoid_seg_sel.
//   modport slave  : the pipeline stage itself
//   modport master : the producer/consumer driving it (testbench, datapath)
// -----------------------------------------------------------------------------
interface sigmoid_seg_sel_if;
  import sigmoid_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t x;
  logic  out_valid;
  logic  out_ready;
  word_t x_abs;
  word_t gradient;
  word_t offset;
  logic  neg;
  logic  sat;

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, x_abs, gradient, offset, neg, sat
  );

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, x_abs, gradient, offset, neg, sat
  );

endinterface

// File: rtl/sigmoid_coef_tbl.sv
// -----------------------------------------------------------------------------
// sigmoid_coef_tbl
// Gradient/offset table with combinational lookup by segment index.
// Build option SIGMOID_COEF_WR_EN:
//   defined   : register file, reloaded with defaults on reset, written via
//               i_coef_* (addresses >= NSEG are dropped). A lookup in the write
//               cycle sees the old entry because the read is from the flops.
//   undefined : constant table from sigmoid_pkg, no clock needed.
// Ports: clk, rst_n, i_coef_we, i_coef_addr, i_coef_grad, i_coef_off (option
//        only); i_seg lookup index; o_grad/o_off selected entry (0 if i_seg
//        is out of range).
// -----------------------------------------------------------------------------
module sigmoid_coef_tbl
  import sigmoid_pkg::*;
(
`ifdef SIGMOID_COEF_WR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_coef_we,
  input  logic [2:0] i_coef_addr,
  input  word_t      i_coef_grad,
  input  word_t      i_coef_off,
`endif
  input  seg_t       i_seg,
  output word_t      o_grad,
  output word_t      o_off
);

`ifdef SIGMOID_COEF_WR_EN
  word_t r_grad [NSEG];
  word_t r_off  [NSEG];

  // Coefficient register file: defaults on reset, in-range writes otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        r_grad[i] <= DEF_GRAD[i];
        r_off[i]  <= DEF_OFF[i];
      end
    end else if (i_coef_we && (i_coef_addr < 3'(NSEG))) begin
      r_grad[i_coef_addr] <= i_coef_grad;
      r_off[i_coef_addr]  <= i_coef_off;
    end else begin
      for (int i = 0; i < NSEG; i++) begin
        r_grad[i] <= r_grad[i];
        r_off[i]  <= r_off[i];
      end
    end
  end

  // Lookup from the current register contents.
  always_comb begin
    o_grad = 16'h0000;
    o_off  = 16'h0000;
    if (i_seg < seg_t'(NSEG)) begin
      o_grad = r_grad[i_seg[2:0]];
      o_off  = r_off[i_seg[2:0]];
    end else begin
      o_grad = 16'h0000;
      o_off  = 16'h0000;
    end
  end
`else
  // Lookup from the constant default table.
  always_comb begin
    o_grad = 16'h0000;
    o_off  = 16'h0000;
    if (i_seg < seg_t'(NSEG)) begin
      o_grad = DEF_GRAD[i_seg[2:0]];
      o_off  = DEF_OFF[i_seg[2:0]];
    end else begin
      o_grad = 16'h0000;
      o_off  = 16'h0000;
    end
  end
`endif

endmodule

// File: rtl/sigmoid_seg_sel.sv
// -----------------------------------------------------------------------------
// sigmoid_seg_sel
// Two-stage valid/ready front end of the piecewise-linear sigmoid. Stage 1
// folds the Q8.8 sample onto the positive axis and flags sign/saturation;
// stage 2 looks up the segment coefficients and holds the result for the
// multiply-add stage. The ready chain is combinational (no skid buffer).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : in_valid/in_ready/x, out_valid/out_ready,
//                       x_abs/gradient/offset/neg/sat
//   i_coef_*          : coefficient write port (SIGMOID_COEF_WR_EN only)
// Build option: SIGMOID_COEF_WR_EN enables the writable coefficient table.
// -----------------------------------------------------------------------------
module sigmoid_seg_sel
  import sigmoid_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
`ifdef SIGMOID_COEF_WR_EN
  input  logic              i_coef_we,
  input  logic [2:0]        i_coef_addr,
  input  word_t             i_coef_grad,
  input  word_t             i_coef_off,
`endif
  sigmoid_seg_sel_if.slave  bus
);

  logic  w_s2_adv;
  logic  w_s1_adv;
  logic  w_accept;
  word_t w_x_abs;
  seg_t  w_seg;
  word_t w_tbl_grad;
  word_t w_tbl_off;

  logic  r_s1_valid;
  word_t r_s1_x_abs;
  logic  r_s1_neg;
  logic  r_s1_sat;

  logic  r_s2_valid;
  word_t r_s2_x_abs;
  word_t r_s2_grad;
  word_t r_s2_off;
  logic  r_s2_neg;
  logic  r_s2_sat;

  // A stage may load when it is empty or its contents leave this cycle.
  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_accept = bus.in_valid && w_s1_adv;
  assign w_x_abs  = fold_abs(bus.x);
  assign w_seg    = r_s1_x_abs[BITS-1:FRAC];

  sigmoid_coef_tbl u_tbl (
`ifdef SIGMOID_COEF_WR_EN
    .clk         (clk),
    .rst_n       (rst_n),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_grad (i_coef_grad),
    .i_coef_off  (i_coef_off),
`endif
    .i_seg       (w_seg),
    .o_grad      (w_tbl_grad),
    .o_off       (w_tbl_off)
  );

  // Stage 1: capture fold/sign/saturation on accept; empty when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x_abs <= 16'h0000;
      r_s1_neg   <= 1'b0;
      r_s1_sat   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_x_abs <= w_x_abs;
      r_s1_neg   <= bus.x[BITS-1];
      r_s1_sat   <= (w_x_abs[BITS-1:FRAC] >= seg_t'(NSEG));
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Stage 2: take stage 1 with its coefficients; hold under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_x_abs <= 16'h0000;
      r_s2_grad  <= 16'h0000;
      r_s2_off   <= 16'h0000;
      r_s2_neg   <= 1'b0;
      r_s2_sat   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_x_abs <= r_s1_x_abs;
        r_s2_grad  <= r_s1_sat ? 16'h0000 : w_tbl_grad;
        r_s2_off   <= r_s1_sat ? SAT_OFFSET : w_tbl_off;
        r_s2_neg   <= r_s1_neg;
        r_s2_sat   <= r_s1_sat;
      end else begin
        r_s2_x_abs <= r_s2_x_abs;
      end
    end else begin
      r_s2_valid <= r_s2_valid;
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.x_abs     = r_s2_x_abs;
  assign bus.gradient  = r_s2_grad;
  assign bus.offset    = r_s2_off;
  assign bus.neg       = r_s2_neg;
  assign bus.sat       = r_s2_sat;

endmodule

// File: tb/tb_sigmoid_seg_sel.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_seg_sel
// Scoreboard bench for sigmoid_seg_sel. Expected results are queued when a
// sample is accepted and checked when the output handshake completes.
// Inputs change 1 time unit after the rising edge; everything is sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_sigmoid_seg_sel;
  import sigmoid_pkg::*;

  typedef struct packed {
    logic [15:0] xa;
    logic [15:0] g;
    logic [15:0] o;
    logic        n;
    logic        s;
  } res_t;

  logic clk;
  logic rst_n;
  logic       coef_we;
  logic [2:0] coef_addr;
  logic [15:0] coef_grad;
  logic [15:0] coef_off;

  sigmoid_seg_sel_if bus ();

  sigmoid_seg_sel dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SIGMOID_COEF_WR_EN
    .i_coef_we   (coef_we),
    .i_coef_addr (coef_addr),
    .i_coef_grad (coef_grad),
    .i_coef_off  (coef_off),
`endif
    .bus         (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb[$];
  logic [15:0] tb_g [6];
  logic [15:0] tb_o [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor: a handshake occurs at the next edge iff valid&&ready now.
  always @(negedge clk) begin
    res_t got;
    res_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got = '{bus.x_abs, bus.gradient, bus.offset, bus.neg, bus.sat};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %h, scoreboard empty", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL result: got xa=%h g=%h o=%h n=%b s=%b, expected xa=%h g=%h o=%h n=%b s=%b",
                   got.xa, got.g, got.o, got.n, got.s, e.xa, e.g, e.o, e.n, e.s);
        end
      end
    end
  end

  task automatic load_default_tbl;
    tb_g = '{16'h003B, 16'h0026, 16'h0012, 16'h0008, 16'h0003, 16'h0001};
    tb_o = '{16'h0080, 16'h0090, 16'h00BD, 16'h00DD, 16'h00F0, 16'h00F9};
  endtask

  function automatic res_t model(input logic [15:0] xv);
    res_t r;
    int v;
    int seg;
    v = int'($signed(xv));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    seg  = v / 256;
    r.xa = v[15:0];
    r.n  = xv[15];
    r.s  = (seg >= 6);
    if (r.s) begin
      r.g = 16'h0000;
      r.o = 16'h0100;
    end else begin
      r.g = tb_g[seg];
      r.o = tb_o[seg];
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one sample until accepted; returns the number of cycles it waited.
  task automatic send(input logic [15:0] xv, input res_t e, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.x = xv;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        acc = 1'b1;
      end else begin
        waited++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: x=%h never accepted", xv);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = 16'h0000;
    bus.out_ready = 1'b0;
    coef_we = 1'b0;
    coef_addr = 3'd0;
    coef_grad = 16'h0000;
    coef_off = 16'h0000;
    load_default_tbl();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_handshake: out_valid,in_ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    n_cmp++;
    if ({bus.x_abs, bus.gradient, bus.offset, bus.neg, bus.sat} !== 50'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", {bus.x_abs, bus.gradient, bus.offset, bus.neg, bus.sat});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.x = 16'h0100;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL lat_accept: in_ready=%b expected 1", bus.in_ready);
    end
    sb.push_back('{16'h0100, 16'h0026, 16'h0090, 1'b0, 1'b0});
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lat_cycle1: out_valid=%b expected 0", bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL lat_cycle2: out_valid=%b expected 1", bus.out_valid);
    end
    tick();
    drain();
  endtask

  task automatic test_vectors;
    int w;
    int wsum;
    wsum = 0;
    bus.out_ready = 1'b1;
    send(16'h0000, '{16'h0000, 16'h003B, 16'h0080, 1'b0, 1'b0}, w); wsum += w;
    send(16'hFF00, '{16'h0100, 16'h0026, 16'h0090, 1'b1, 1'b0}, w); wsum += w;
    send(16'h0480, '{16'h0480, 16'h0003, 16'h00F0, 1'b0, 1'b0}, w); wsum += w;
    send(16'h0600, '{16'h0600, 16'h0000, 16'h0100, 1'b0, 1'b1}, w); wsum += w;
    send(16'h8000, '{16'h7FFF, 16'h0000, 16'h0100, 1'b1, 1'b1}, w); wsum += w;
    send(16'h05FF, '{16'h05FF, 16'h0001, 16'h00F9, 1'b0, 1'b0}, w); wsum += w;
    send(16'hFA01, '{16'h05FF, 16'h0001, 16'h00F9, 1'b1, 1'b0}, w); wsum += w;
    send(16'hFA00, '{16'h0600, 16'h0000, 16'h0100, 1'b1, 1'b1}, w); wsum += w;
    n_cmp++;
    if (wsum !== 0) begin
      n_err++;
      $display("FAIL throughput: %0d stall cycles with out_ready=1, expected 0", wsum);
    end
    drain();
  endtask

  task automatic test_backpressure;
    res_t e0;
    e0 = '{16'h0000, 16'h003B, 16'h0080, 1'b0, 1'b0};
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.x = 16'h0000;
    @(negedge clk);
    if (bus.in_ready) sb.push_back(e0);
    tick();
    bus.x = 16'h0100;
    @(negedge clk);
    if (bus.in_ready) sb.push_back('{16'h0100, 16'h0026, 16'h0090, 1'b0, 1'b0});
    tick();
    bus.x = 16'h0200;
    n_cmp++;
    if (sb.size() !== 2) begin
      n_err++;
      $display("FAIL bp_accepts: %0d accepted, expected 2", sb.size());
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.x_abs, bus.gradient, bus.offset} !== {1'b0, 1'b1, e0.xa, e0.g, e0.o}) begin
        n_err++;
        $display("FAIL bp_hold: in_ready=%b out_valid=%b xa=%h g=%h o=%h, expected 0 1 %h %h %h",
                 bus.in_ready, bus.out_valid, bus.x_abs, bus.gradient, bus.offset, e0.xa, e0.g, e0.o);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: in_ready=%b expected 1", bus.in_ready);
    end else begin
      sb.push_back('{16'h0200, 16'h0012, 16'h00BD, 1'b0, 1'b0});
    end
    tick();
    bus.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_random;
    bit done;
    int w;
    logic [15:0] xv;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          xv = 16'($urandom);
          if (i % 4 == 0) xv = {xv[15], 7'h00, xv[7:0]} ^ 16'h0300;
          send(xv, model(xv), w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
  endtask

`ifdef SIGMOID_COEF_WR_EN
  task automatic write_coef(input logic [2:0] a, input logic [15:0] g, input logic [15:0] o);
    coef_we = 1'b1;
    coef_addr = a;
    coef_grad = g;
    coef_off = o;
    tick();
    coef_we = 1'b0;
    if (a < 3'd6) begin
      tb_g[a] = g;
      tb_o[a] = o;
    end
  endtask

  task automatic test_coef_write;
    int w;
    bus.out_ready = 1'b1;
    write_coef(3'd2, 16'h0014, 16'h00C0);
    send(16'h0280, '{16'h0280, 16'h0014, 16'h00C0, 1'b0, 1'b0}, w);
    write_coef(3'd7, 16'hFFFF, 16'hFFFF);
    write_coef(3'd6, 16'hEEEE, 16'hEEEE);
    for (int k = 0; k < 6; k++) begin
      send(16'(k * 256 + 16'h0040), model(16'(k * 256 + 16'h0040)), w);
    end
    drain();
  endtask
`endif

  task automatic test_reset_midstream;
    int w;
    bus.out_ready = 1'b0;
    send(16'h0300, model(16'h0300), w);
    send(16'h0400, model(16'h0400), w);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rst_mid: out_valid,in_ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    sb.delete();
    load_default_tbl();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rst_release: out_valid,in_ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    tick();
    bus.out_ready = 1'b1;
    send(16'h0200, '{16'h0200, 16'h0012, 16'h00BD, 1'b0, 1'b0}, w);
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_random();
`ifdef SIGMOID_COEF_WR_EN
    test_coef_write();
`endif
    test_reset_midstream();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
